// File: rtl/prewish_mask_responder_pkg.sv
// Shared types and widths for the mask responder: FSM encoding and mask geometry.
package prewish_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACK      = 2'd1,
    ST_WAIT_LOW = 2'd2
  } state_t;

  localparam int MASK_W     = 8;
  localparam int MASK_IDX_W = 3;

endpackage

// File: rtl/prewish_mask_responder_if.sv
// Strobe/data/acknowledge bus between the controller (master) and the responder (slave).
interface prewish_mask_responder_if;
  import prewish_pkg::*;

  logic              STB_I;
  logic [MASK_W-1:0] DAT_I;
  logic              ACK_O;

  modport master (output STB_I, output DAT_I, input  ACK_O);
  modport slave  (input  STB_I, input  DAT_I, output ACK_O);

endinterface

// File: rtl/prewish_mask_responder_clkdiv.sv
// Free-running mask-step counter; o_wrap marks the wrap edge, o_step is its registered pulse.
module prewish_mask_clkdiv #(
  parameter int BLINKY_MASK_CLK_BITS = 19
) (
  input  logic CLK_I,
  input  logic RST_I,
  input  logic i_clr,
  output logic o_wrap,
  output logic o_step
);

  logic [BLINKY_MASK_CLK_BITS-1:0] r_cnt;
  logic                            r_step;
  logic                            w_wrap;

  // A clear on the wrap edge wins, so no step is produced for that cycle.
  assign w_wrap = (r_cnt == '1) && !i_clr;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_cnt  <= '0;
      r_step <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_step <= 1'b0;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_step <= w_wrap;
    end
  end

  assign o_wrap = w_wrap;
  assign o_step = r_step;

endmodule

// File: rtl/prewish_mask_responder.sv
// Accepts an 8-bit blink mask over a strobe/ack bus and walks it onto o_led, MSB first.
// Build option PREWISH_ACTIVE_LOW_MASK_EN stores the inverse of DAT_I (active-low DIP switches).
module prewish_mask_responder
  import prewish_pkg::*;
#(
  parameter int BLINKY_MASK_CLK_BITS = 19
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  prewish_mask_responder_if.slave  bus,
  output logic                     o_led,
  output logic                     o_step
);

  state_t                r_state;
  logic [MASK_W-1:0]     r_mask;
  logic [MASK_IDX_W-1:0] r_idx;
  logic                  r_ack;
  logic                  r_led;
  logic                  w_capture;
  logic                  w_wrap;
  logic                  w_step;
  logic [MASK_W-1:0]     w_dat_eff;

`ifdef PREWISH_ACTIVE_LOW_MASK_EN
  assign w_dat_eff = ~bus.DAT_I;
`else
  assign w_dat_eff = bus.DAT_I;
`endif

  assign w_capture = (r_state == ST_IDLE) && bus.STB_I;

  prewish_mask_clkdiv #(
    .BLINKY_MASK_CLK_BITS(BLINKY_MASK_CLK_BITS)
  ) u_clkdiv (
    .CLK_I  (CLK_I),
    .RST_I  (RST_I),
    .i_clr  (w_capture),
    .o_wrap (w_wrap),
    .o_step (w_step)
  );

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state <= ST_IDLE;
      r_mask  <= '0;
      r_idx   <= '1;
      r_ack   <= 1'b0;
      r_led   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.STB_I) begin
            r_state <= ST_ACK;
            r_ack   <= 1'b1;
            r_mask  <= w_dat_eff;
          end
        end
        ST_ACK:      r_state <= ST_WAIT_LOW;
        ST_WAIT_LOW: if (!bus.STB_I) r_state <= ST_IDLE;
        default:     r_state <= ST_IDLE;
      endcase

      // Index moves on the same edge the counter wraps; 0 rolls over to 7.
      if (w_capture)
        r_idx <= '1;
      else if (w_wrap)
        r_idx <= r_idx - 1'b1;

      r_led <= r_mask[r_idx];
    end
  end

  assign bus.ACK_O = r_ack;
  assign o_led     = r_led;
  assign o_step    = w_step;

endmodule
